// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: shift-add multiply, restoring divide, MTHI/MTLO.
// Latency: MULT/MULTU/DIV/DIVU take WIDTH+1 edges from accept to HI/LO update; MTHI/MTLO take one edge.
// Backpressure: busy_o stalls the pipeline; start_i is ignored while busy, and flush_i aborts in flight.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             dbz_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;     // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opnd_q;    // multiplicand or divisor magnitude
    logic               is_div_q;
    logic               sgnq_q;
    logic               sgnr_q;
    logic               dbz_pend_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               is_mul_op;
    logic               is_div_op;
    logic               b_zero;
    logic               conv;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // Decode the request and form operand magnitudes for the accept edge
    always_comb begin
        is_mul_op = (op_i == OP_MULT) || (op_i == OP_MULTU);
        is_div_op = (op_i == OP_DIV)  || (op_i == OP_DIVU);
        b_zero    = (b_i == '0);
        // A zero divisor skips sign handling: the raw dividend then shifts straight
        // through the remainder while every quotient bit comes out as one.
        conv      = (op_i == OP_MULT) || ((op_i == OP_DIV) && !b_zero);
        a_mag     = (conv && a_i[WIDTH-1]) ? -a_i : a_i;
        b_mag     = (conv && b_i[WIDTH-1]) ? -b_i : b_i;
    end

    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               qbit;
    logic [2*WIDTH-1:0] step_next;

    // One iteration: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, opnd_q};
        qbit   = ~diff[WIDTH];
        if (is_div_q) begin
            step_next = {(qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], qbit};
        end else begin
            step_next = {msum, acc_q[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // Sign correction applied on the FIX edge
    always_comb begin
        mul_res = sgnq_q ? -acc_q : acc_q;
        if (is_div_q) begin
            fix_lo = sgnq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            fix_hi = sgnr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
            fix_lo = mul_res[WIDTH-1:0];
            fix_hi = mul_res[2*WIDTH-1:WIDTH];
        end
    end

    // Control FSM with registered status outputs and HI/LO registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            sgnq_q     <= 1'b0;
            sgnr_q     <= 1'b0;
            dbz_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (is_mul_op || is_div_op) begin
                            state_q    <= ITER;
                            busy_q     <= 1'b1;
                            cnt_q      <= CW'(WIDTH);
                            is_div_q   <= is_div_op;
                            sgnq_q     <= conv && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                            sgnr_q     <= conv && a_i[WIDTH-1];
                            dbz_pend_q <= is_div_op && b_zero;
                            acc_q      <= {{WIDTH{1'b0}}, (is_div_op ? a_mag : b_mag)};
                            opnd_q     <= is_div_op ? b_mag : a_mag;
                        end else if (op_i == OP_MTHI) begin
                            hi_q <= a_i;
                        end else if (op_i == OP_MTLO) begin
                            lo_q <= a_i;
                        end
                    end
                end
                ITER: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        acc_q <= step_next;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!flush_i) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                        dbz_q  <= dbz_pend_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign dbz_o  = dbz_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Every comparison is an immediate assertion against hand-computed values.
module tb_muldiv_unit;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op    = 3'b000;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] cur_hi   = '0;
    logic [31:0] cur_lo   = '0;
    logic        seen;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .flush_i (flush),
        .busy_o  (busy),
        .done_o  (done),
        .dbz_o   (dbz),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue an iterative op, time the busy window, then check the done-cycle result.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic edbz);
        int cyc;
        cyc   = 0;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_hold_hi"}, hi, cur_hi);
        chk({tag, "_hold_lo"}, lo, cur_lo);
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 32'(cyc), 32'd33);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_hi"}, hi, ehi);
        chk({tag, "_lo"}, lo, elo);
        chk({tag, "_dbz"}, {31'd0, dbz}, {31'd0, edbz});
        cur_hi = ehi;
        cur_lo = elo;
    endtask

    task automatic post_done(input string tag);
        tick();
        chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        chk({tag, "_dbz_drop"}, {31'd0, dbz}, 32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dbz", {31'd0, dbz}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // MTHI with flush in IDLE: flush has no effect, write is single-cycle
        op = 3'b100; a = 32'h12345678; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_done", {31'd0, done}, 32'd0);
        cur_hi = 32'h12345678;

        op = 3'b101; a = 32'h0BADF00D; start = 1'b1;
        tick();
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h0BADF00D);
        chk("mtlo_hi", hi, cur_hi);
        cur_lo = 32'h0BADF00D;

        // Illegal ops are ignored
        op = 3'b110; a = 32'hFFFFFFFF; b = 32'h1; start = 1'b1;
        tick();
        op = 3'b111;
        tick();
        start = 1'b0;
        chk("illegal_busy", {31'd0, busy}, 32'd0);
        chk("illegal_hi", hi, cur_hi);
        chk("illegal_lo", lo, cur_lo);

        // -3 * 7 = -21, then a back-to-back start in the done cycle
        run_op("mult", 3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run_op("multu", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        post_done("multu");

        run_op("divu", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        post_done("divu");
        run_op("div_neg", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        post_done("div_neg");
        run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        post_done("div_ovf");
        run_op("div_by0", 3'b010, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1);
        post_done("div_by0");
        run_op("div_neg_by0", 3'b010, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
        post_done("div_neg_by0");

        // Flush in ITER; an MTHI start while busy is ignored
        op = 3'b000; a = 32'd3; b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            start = (i == 5);
            if (i == 5) begin
                op = 3'b100;
                a  = 32'hDEADBEEF;
            end
            tick();
        end
        start = 1'b0;
        chk("flush_pre_busy", {31'd0, busy}, 32'd1);
        chk("busy_start_ignored_hi", hi, cur_hi);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_hi", hi, cur_hi);
        chk("flush_lo", lo, cur_lo);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        chk("flush_no_done", {31'd0, seen}, 32'd0);
        chk("flush_hi_late", hi, cur_hi);

        // Flush in FIX overrides the result update
        op = 3'b001; a = 32'd2; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (32) tick();
        chk("fix_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fixflush_done", {31'd0, done}, 32'd0);
        chk("fixflush_busy", {31'd0, busy}, 32'd0);
        chk("fixflush_lo", lo, cur_lo);
        chk("fixflush_hi", hi, cur_hi);

        // Asynchronous reset mid-DIV
        op = 3'b010; a = 32'd100; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_dbz", {31'd0, dbz}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        cur_hi = '0;
        cur_lo = '0;

        // First start after release is taken on the first edge with reset high
        @(negedge clk);
        rst_n = 1'b1;
        op = 3'b101; a = 32'hCAFEF00D; start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_rst_mtlo", lo, 32'hCAFEF00D);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        cur_lo = 32'hCAFEF00D;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        chk("post_rst_no_done", {31'd0, seen}, 32'd0);

        run_op("divu_big", 3'b011, 32'hFFFFFFFF, 32'd10, 32'd5, 32'h19999999, 1'b0);
        post_done("divu_big");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
